seq_detector_param: RTL

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_det_match.sv | 37 +++
 rtl/seq_detector_param.sv | 102 ++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared widths, pattern typedef and helpers for the parameterised sequence detector.
// Optional detection counter is enabled with macro SEQ_DET_COUNT_EN.
package seq_det_pkg;

  localparam int SEQ_DIGIT_W = 4;
  localparam int SEQ_MAX_LEN = 16;
  localparam int SEQ_IDX_W   = $clog2(SEQ_MAX_LEN);
  localparam int SEQ_LEN_W   = SEQ_IDX_W + 1;
  localparam int CNT_W       = 16;

  typedef logic [SEQ_DIGIT_W-1:0] digit_t;
  typedef digit_t [SEQ_MAX_LEN-1:0] pattern_t;

  // Element 0 is the first digit of the pattern: 2,0,1,6,1,3,1,1.
  localparam pattern_t SEQ_DEFAULT = pattern_t'(64'h1131_6102);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// Combinational suffix comparator: the newest len digits (current digit plus history)
// against pattern[0..len-1]. Element 0 of the history is the most recent accepted digit.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter  int DIGIT_W = SEQ_DIGIT_W,
  parameter  int MAX_LEN = SEQ_MAX_LEN,
  localparam int IDX_W   = $clog2(MAX_LEN),
  localparam int LEN_W   = IDX_W + 1
) (
  input  logic [MAX_LEN-1:0][DIGIT_W-1:0] hist_i,
  input  logic [DIGIT_W-1:0]              num_i,
  input  logic [MAX_LEN-1:0][DIGIT_W-1:0] pat_i,
  input  logic [LEN_W-1:0]                len_i,
  output logic                            match_o
);

  logic [MAX_LEN-1:0][DIGIT_W-1:0] win;
  logic [LEN_W-1:0]                pidx;
  logic                            unused_oldest;

  // The oldest stored digit can never fall inside a window of at most MAX_LEN digits.
  assign unused_oldest = ^hist_i[MAX_LEN-1];

  always_comb begin
    win     = {hist_i[MAX_LEN-2:0], num_i};
    match_o = (len_i != '0) && (len_i <= LEN_W'(MAX_LEN));
    pidx    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_i) begin
        pidx = len_i - LEN_W'(i) - LEN_W'(1);
        if (win[i] != pat_i[pidx[IDX_W-1:0]]) match_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable digit sequence detector with Mealy detect output.
// Define SEQ_DET_COUNT_EN to enable the saturating det_count counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int DIGIT_W     = SEQ_DIGIT_W,
  parameter  int MAX_LEN     = SEQ_MAX_LEN,
  parameter  int DEFAULT_LEN = 8,
  parameter  logic [MAX_LEN-1:0][DIGIT_W-1:0] DEFAULT_SEQ =
               (MAX_LEN*DIGIT_W)'(64'h1131_6102),
  localparam int IDX_W       = $clog2(MAX_LEN),
  localparam int LEN_W       = IDX_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] in_num,
  input  logic               overlap_en,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [DIGIT_W-1:0] cfg_digit,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               detected,
  output logic [LEN_W-1:0]   fill,
  output logic [CNT_W-1:0]   det_count
);

  logic [MAX_LEN-1:0][DIGIT_W-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0][DIGIT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic [LEN_W-1:0]                fill_q, fill_d;
  logic                            accept, fill_ok, match;

  assign accept   = in_valid & ~cfg_we;
  assign fill_ok  = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
  assign detected = rst_n & accept & fill_ok & match;
  assign fill     = fill_q;

  seq_det_match #(
    .DIGIT_W (DIGIT_W),
    .MAX_LEN (MAX_LEN)
  ) u_match (
    .hist_i  (hist_q),
    .num_i   (in_num),
    .pat_i   (pat_q),
    .len_i   (len_q),
    .match_o (match)
  );

  always_comb begin
    hist_d = hist_q;
    pat_d  = pat_q;
    len_d  = len_q;
    fill_d = fill_q;
    if (cfg_we) begin
      if ({1'b0, cfg_idx} < LEN_W'(MAX_LEN)) pat_d[cfg_idx] = cfg_digit;
      if (cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN)) len_d = cfg_len;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = {hist_q[MAX_LEN-2:0], in_num};
      // Non-overlap restarts the count so no digit serves two detections.
      if (detected && !overlap_en)         fill_d = '0;
      else if (fill_q != LEN_W'(MAX_LEN))  fill_d = fill_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
      pat_q  <= DEFAULT_SEQ;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i >= DEFAULT_LEN) pat_q[i] <= '0;
      end
      len_q  <= LEN_W'(DEFAULT_LEN);
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      fill_q <= fill_d;
    end
  end

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (detected) cnt_d = sat_inc_cnt(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign det_count = cnt_q;
`else
  assign det_count = '0;
`endif

endmodule
